// File: rtl/regfile_dump.sv
// regfile_dump: walks the architectural register file x0..x(NUM_REGS-1)
// through an asynchronous read port and streams each value out on a
// valid/ready interface tagged with its index and a last flag. The core is
// stalled for the whole dump.
//
// Optional build macro: DUMP_BYTE_MODE_EN
//   undefined (default): out_data is DATA_W bits, one beat per register.
//   defined:             out_data is 8 bits, four beats per register,
//                        least-significant byte first (DATA_W must be 32).
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              core_stall,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef DUMP_BYTE_MODE_EN
    output logic [7:0]        out_data,
`else
    output logic [DATA_W-1:0] out_data,
`endif
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
`ifdef DUMP_BYTE_MODE_EN
    logic [1:0]         byte_q, byte_d;
`endif

    logic handshake;
    logic last_reg;
    logic last_beat;

    // Next-state and output decode for the dump sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
`ifdef DUMP_BYTE_MODE_EN
        byte_d     = byte_q;
`endif
        busy       = (state_q != IDLE);
        core_stall = (state_q != IDLE);
        done       = (state_q == DONE);
        out_valid  = (state_q == SEND);
        rf_raddr   = idx_q;
        handshake  = out_valid && out_ready;
        last_reg   = (idx_q == LAST_IDX);
`ifdef DUMP_BYTE_MODE_EN
        last_beat  = last_reg && (byte_q == 2'd3);
        out_data   = out_valid ? data_q[{byte_q, 3'b000} +: 8] : 8'd0;
`else
        last_beat  = last_reg;
        out_data   = out_valid ? data_q : '0;
`endif
        out_index  = out_valid ? idx_q : '0;
        out_last   = out_valid && last_beat;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
`ifdef DUMP_BYTE_MODE_EN
                    byte_d  = 2'd0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = rf_rdata;
                state_d = SEND;
            end
            SEND: begin
                if (handshake) begin
`ifdef DUMP_BYTE_MODE_EN
                    if (byte_q != 2'd3) begin
                        byte_d = byte_q + 2'd1;
                    end else begin
                        byte_d = 2'd0;
`endif
                        if (last_reg) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = LOAD;
                        end
`ifdef DUMP_BYTE_MODE_EN
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides start and any handshake; it is meaningless in IDLE.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // State, index and captured-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            // NOTE: data_q is a single holding register, not a memory array,
            // so resetting it is cheap and keeps out_data defined after reset.
            data_q  <= '0;
`ifdef DUMP_BYTE_MODE_EN
            byte_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
`ifdef DUMP_BYTE_MODE_EN
            byte_q  <= byte_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump. A behavioural register
// file answers the asynchronous read port; each dump is followed beat by beat
// against the expected index/data/last sequence. Honours DUMP_BYTE_MODE_EN.
module tb_regfile_dump;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;
`ifdef DUMP_BYTE_MODE_EN
    localparam int          BPR  = 4;
    localparam logic [31:0] MASK = 32'h0000_00FF;
`else
    localparam int          BPR  = 1;
    localparam logic [31:0] MASK = 32'hFFFF_FFFF;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              core_stall;
    logic [IDX_W-1:0]  rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              out_valid;
    logic              out_ready;
`ifdef DUMP_BYTE_MODE_EN
    logic [7:0]        out_data;
`else
    logic [DATA_W-1:0] out_data;
`endif
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf [NUM_REGS];

    int checks = 0;
    int errors = 0;

    assign rf_rdata = rf[rf_raddr];

    always #5 clk = ~clk;

    regfile_dump #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .core_stall (core_stall),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_stall"}, core_stall, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_last"},  out_last, 0);
        check({tag, "_data"},  32'(out_data), 0);
        check({tag, "_index"}, 32'(out_index), 0);
    endtask

    // One dump from a start pulse. drop_at: index whose first beat sees
    // out_ready low for 3 cycles. abort_at: index at which abort is raised
    // (with a coinciding handshake). restart_at: index at which a stray
    // start is pulsed. start_in_done: pulse start in the DONE cycle.
    // A negative index disables that stimulus.
    task automatic run_dump(input int drop_at, input int abort_at,
                            input int restart_at, input bit start_in_done);
        int exp_idx = 0;
        int exp_b   = 0;
        int drops   = 0;
        int k       = 0;
        int first_k = -1;
        int done_k  = -1;
        int n_done  = 0;
        int n_beats = 0;
        bit fin     = 0;
        bit restarted = 0;
        bit abort_now, was_done;
        logic [31:0] w;

        start = 1'b1;
        step();
        start = 1'b0;
        check("load_valid", out_valid, 0);

        while (!fin && k < 400) begin
            abort_now = 0;
            was_done  = 0;
            out_ready = 1'b1;
            check("dump_stall", core_stall, 1);
            check("dump_busy", busy, 1);
            if (done) begin
                n_done++;
                done_k   = k;
                was_done = 1;
                if (start_in_done) start = 1'b1;
            end
            if (out_valid) begin
                if (first_k < 0) first_k = k;
                w = rf[exp_idx] >> (8 * exp_b);
                check("beat_index", 32'(out_index), 32'(exp_idx));
                check("beat_data", 32'(out_data), w & MASK);
                check("beat_last", out_last,
                      32'((exp_idx == NUM_REGS - 1) && (exp_b == BPR - 1)));
                if (exp_idx == drop_at && exp_b == 0 && drops < 3) begin
                    out_ready = 1'b0;
                    drops++;
                end
                if (exp_idx == abort_at) begin
                    abort     = 1'b1;
                    abort_now = 1;
                end
                if (exp_idx == restart_at && !restarted) begin
                    start     = 1'b1;
                    restarted = 1;
                end
                if (out_ready) begin
                    n_beats++;
                    exp_b++;
                    if (exp_b == BPR) begin
                        exp_b = 0;
                        exp_idx++;
                    end
                end
            end
            step();
            k++;
            start = 1'b0;
            abort = 1'b0;
            if (abort_now) begin
                check_idle_outputs("post_abort");
                fin = 1;
            end
            if (was_done) begin
                check_idle_outputs("post_done");
                fin = 1;
            end
        end
        check("dump_terminated", fin, 1);

        if (abort_at < 0) begin
            check("first_valid_latency", 32'(first_k), 1);
            check("done_cycle", 32'(done_k),
                  32'((BPR + 1) * NUM_REGS + ((drop_at >= 0) ? 3 : 0)));
            check("done_count", 32'(n_done), 1);
            check("beat_count", 32'(n_beats), 32'(NUM_REGS * BPR));
        end else begin
            check("abort_no_done", 32'(n_done), 0);
        end
        if (start_in_done) begin
            step();
            check("start_in_done_ignored", busy, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
        rf[10] = 32'd5;
`ifdef DUMP_BYTE_MODE_EN
        rf[11] = 32'h1234_5678;
`else
        rf[11] = 32'd7;
`endif
        rf[12] = 32'd12;

        // Reset state.
        step();
        step();
        check_idle_outputs("reset");
        check("reset_raddr", 32'(rf_raddr), 0);
        rst = 1'b0;

        // Abort in IDLE is ignored.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle_outputs("idle_abort");

        // Full dump, stray start at index 6 and in the DONE cycle.
        run_dump(-1, -1, 6, 1'b1);

        // Backpressure: ready low for 3 cycles while index 10 is presented.
        run_dump(10, -1, -1, 1'b0);

        // Abort while presenting index 4, then confirm no late done.
        run_dump(-1, 4, -1, 1'b0);
        step();
        step();
        check_idle_outputs("abort_settle");

        // Clean dump after the abort.
        run_dump(-1, -1, -1, 1'b0);

`ifdef DUMP_BYTE_MODE_EN
        // Directed byte order for x11: walk to its first beat.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 400 && !(out_valid && out_index == 5'd11); i++) step();
        check("byte0_x11", 32'(out_data), 32'h78);
        step();
        check("byte1_x11", 32'(out_data), 32'h56);
        step();
        check("byte2_x11", 32'(out_data), 32'h34);
        step();
        check("byte3_x11", 32'(out_data), 32'h12);
        check("byte3_x11_last", out_last, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif

        // Synchronous reset in a SEND cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_index", 32'(out_index), (BPR == 1) ? 32'd1 : 32'd0);
        rst = 1'b1;
        step();
        check_idle_outputs("send_rst");
        check("send_rst_raddr", 32'(rf_raddr), 0);
        rst = 1'b0;
        step();
        step();
        step();
        check_idle_outputs("post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Hardware readout engine for the core's architectural register file; the on-chip reader counterpart to the bench-side register loading and dumping.
- On a start pulse, stalls the core, walks x0..x(NUM_REGS-1) through a register-file read port, and streams each value out on a valid/ready interface, tagged with its index and a last flag.
- Sits beside the `riscv` top; the stream feeds a debug UART or trace sink.

Parameters:
- NUM_REGS, 32: registers dumped, from index 0 upward.
- DATA_W, 32: register width.
- IDX_W, 5: index width; must satisfy 2**IDX_W >= NUM_REGS.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a dump.
- abort  in  1  terminate the dump in progress.
- core_stall  out  1  high while dumping; core must not write the regfile.
- rf_raddr  out  IDX_W  regfile read address; the read port is asynchronous.
- rf_rdata  in  DATA_W  regfile read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  DATA_W (8 with DUMP_BYTE_MODE_EN)  stream payload.
- out_index  out  IDX_W  register index of the current payload.
- out_last  out  1  final beat of the dump.
- busy  out  1  engine not idle.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst high at clk edge): state IDLE, idx=0, data_q=0; out_valid, out_last, busy, done, core_stall all 0; out_data=0, out_index=0, rf_raddr=0.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - busy=0, core_stall=0.
  - start=1 -> idx=0, go to LOAD.
  - abort in IDLE is ignored.
- LOAD (one cycle):
  - rf_raddr=idx; busy=1, core_stall=1.
  - At the edge, data_q<=rf_rdata and go to SEND.
- SEND:
  - out_valid=1, out_data=data_q, out_index=idx, out_last=(idx==NUM_REGS-1).
  - Handshake completes on a cycle with out_valid&&out_ready.
  - Not last: idx<=idx+1, go to LOAD.
  - Last: go to DONE.
- Stall rule: while out_valid=1 and out_ready=0, out_data, out_index and out_last stay stable. out_valid never drops without a handshake, except on abort or rst.
- DONE (one cycle): done=1, busy=1, core_stall=1; next state IDLE.
- Latency: start high at edge N -> out_valid first high in cycle N+2.
- Throughput: with out_ready tied high, one word per 2 cycles; full dump is 2*NUM_REGS+1 cycles from start to done.
- out_ready high while out_valid=0 has no effect.
- start while busy=1 is ignored, including in the DONE cycle.
- abort=1 in LOAD/SEND/DONE:
  - Next state IDLE; out_valid, busy and core_stall fall at that edge; no done pulse.
  - If abort coincides with a handshake, the beat counts as transferred but the engine still goes to IDLE.
- rst has priority over abort, which has priority over start and handshake.
- x0 is dumped as read (expected 0); no special-casing.
- idx never wraps; the last beat is idx==NUM_REGS-1.

Optional Feature:
- Macro: DUMP_BYTE_MODE_EN.
- Defined:
  - out_data is 8 bits; each register is sent as 4 beats, least-significant byte first.
  - A 2-bit byte counter advances on each handshake; LOAD occurs only after byte 3 is accepted.
  - out_index is constant across the 4 beats of a register.
  - out_last is high only on byte 3 of register NUM_REGS-1.
  - Full dump with out_ready high is 5*NUM_REGS+1 cycles.
- Not defined: out_data is DATA_W bits, one beat per register; no byte counter is synthesised.

Test Plan:
- Preload x10=5, x11=7, x12=12, others 0; pulse start; out_ready high -> 32 beats with out_index 0..31 and data matching (x10=5, x11=7, x12=12); out_last only on index 31; done pulse 65 cycles after start; core_stall high throughout.
- Backpressure: drop out_ready for 3 cycles while index 10 is presented -> out_data=5 and out_index=10 held stable; no duplicate or skipped beats.
- Abort while presenting index 4 -> out_valid, busy, core_stall low at next edge; no done; a new start gives a clean dump from index 0.
- start pulsed at index 6 mid-dump -> ignored; sequence unchanged; single done.
- rst asserted in a SEND cycle -> all outputs return to reset values at the next edge; output stays idle until a new start.
- With DUMP_BYTE_MODE_EN and x11=0x12345678 -> beats for index 11 are 0x78, 0x56, 0x34, 0x12; out_last on byte 3 of index 31 only.
